fetch_prefetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined RSA CPU. It generalises the fixed 32-bit PC control path into a configurable-width PC generator with a start gate, a DEPTH-entry prefetch queue, a valid/ready handshake toward decode and flush-on-redirect from execute. It sits between the synchronous instruction memory and the decode stage, and replaces direct PC-to-decode wiring in the core top.

---
 rtl/fetch_prefetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - PC generator, prefetch queue and decode handshake
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_flushed counters.
module fetch_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    output logic                       dec_valid,
    output logic [XLEN-1:0]            dec_instr,
    output logic [XLEN-1:0]            dec_pc,
    input  logic                       dec_ready,
    output logic                       running,
`ifdef FETCH_PERF_EN
    output logic [31:0]                perf_fetched,
    output logic [31:0]                perf_flushed,
`endif
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, stateNext;
    logic [XLEN-1:0] fetchPc, tagPc;
    logic            inflight;
    logic [PW-1:0]   rdPtr, wrPtr;
    logic [OW-1:0]   count;
    logic [OW:0]     pending;
    logic            issue, push, pop, decValid;
    logic [XLEN-1:0] instrQ [DEPTH];
    logic [XLEN-1:0] pcQ    [DEPTH];

    // Entries already queued plus the one response still on its way from memory.
    assign pending  = (OW+1)'(count) + (OW+1)'(inflight);
    assign decValid = (count != '0) && !redirect;
    assign pop      = decValid && dec_ready;
    assign push     = inflight && !redirect && (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        issue     = 1'b0;
        unique case (state)
            IDLE: if (start) stateNext = RUN;
            RUN:  issue = !redirect && (pending < (OW+1)'(DEPTH) + (OW+1)'(pop));
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc  <= RESET_PC;
            tagPc    <= '0;
            inflight <= 1'b0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
        end else if (state == RUN) begin
            if (redirect) begin
                fetchPc  <= redirect_pc;
                inflight <= 1'b0;
                rdPtr    <= '0;
                wrPtr    <= '0;
                count    <= '0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    tagPc   <= fetchPc;
                    fetchPc <= fetchPc + XLEN'(PC_STEP);
                end
                if (push) wrPtr <= wrPtr + PW'(1);
                if (pop)  rdPtr <= rdPtr + PW'(1);
                unique case ({push, pop})
                    2'b10:   count <= count + OW'(1);
                    2'b01:   count <= count - OW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (push) begin
            instrQ[wrPtr] <= imem_rdata;
            pcQ[wrPtr]    <= tagPc;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = issue ? fetchPc : '0;
    assign dec_valid = decValid;
    assign dec_instr = decValid ? instrQ[rdPtr] : '0;
    assign dec_pc    = decValid ? pcQ[rdPtr] : '0;
    assign running   = (state == RUN);
    assign occupancy = count;

`ifdef FETCH_PERF_EN
    logic [32:0] flushSum;
    assign flushSum = {1'b0, perf_flushed} + 33'(pending);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (pop && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
            if (state == RUN && redirect) perf_flushed <= flushSum[32] ? 32'hFFFF_FFFF : flushSum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - checks fetch_prefetch_unit against a PC-stream model
module tb_fetch_prefetch_unit;

    localparam int unsigned DEPTH_C [2] = '{4, 2};
    localparam int unsigned STEP_C  [2] = '{4, 4};
    localparam int unsigned MASK_C  [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    localparam int unsigned RESET_C [2] = '{0, 32'hF8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, redirA, readyA, readyB, noRedirB;
    logic [31:0] redirPcA, addrA, rdataA, instrA, pcA;
    logic        reqA, dvA, runA;
    logic [2:0]  occA;
    logic [7:0]  redirPcB, addrB, rdataB, instrB, pcB;
    logic        reqB, dvB, runB;
    logic [1:0]  occB;
`ifdef FETCH_PERF_EN
    logic [31:0] pfA, plA, pfB, plB;
`endif

    fetch_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dutA (
        .clk(clk), .reset(reset), .start(start), .redirect(redirA), .redirect_pc(redirPcA),
        .imem_req(reqA), .imem_addr(addrA), .imem_rdata(rdataA),
        .dec_valid(dvA), .dec_instr(instrA), .dec_pc(pcA), .dec_ready(readyA),
        .running(runA),
`ifdef FETCH_PERF_EN
        .perf_fetched(pfA), .perf_flushed(plA),
`endif
        .occupancy(occA)
    );

    fetch_prefetch_unit #(.XLEN(8), .DEPTH(2), .RESET_PC(8'hF8), .PC_STEP(4)) dutB (
        .clk(clk), .reset(reset), .start(start), .redirect(noRedirB), .redirect_pc(redirPcB),
        .imem_req(reqB), .imem_addr(addrB), .imem_rdata(rdataB),
        .dec_valid(dvB), .dec_instr(instrB), .dec_pc(pcB), .dec_ready(readyB),
        .running(runB),
`ifdef FETCH_PERF_EN
        .perf_fetched(pfB), .perf_flushed(plB),
`endif
        .occupancy(occB)
    );

    // Synchronous ROM: word at address a holds a/4.
    always @(posedge clk) begin
        rdataA <= addrA >> 2;
        rdataB <= addrB >> 2;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, i, $time, got, want);
        end
    endtask

    // The decode stream is a run of consecutive PCs: head PC, queued count, one pending response.
    bit          mRun  [2];
    int unsigned mHead [2];
    int unsigned mN    [2];
    int unsigned mPend [2];
    int unsigned mFe   [2];
    int unsigned mFl   [2];
    bit          modelOn = 1'b0;

    task automatic model_reset(input int i);
        mRun[i]  = 1'b0;
        mHead[i] = RESET_C[i];
        mN[i]    = 0;
        mPend[i] = 0;
        mFe[i]   = 0;
        mFl[i]   = 0;
    endtask

    task automatic model_step(input int i, input logic rst, input logic st, input logic rd,
                              input logic [31:0] rdPc, input logic rdy, input logic req,
                              input logic [31:0] addr, input logic dv, input logic [31:0] di,
                              input logic [31:0] dp, input logic [31:0] occ, input logic run);
        bit          eDv, pop, eReq;
        longint      sum;
        eDv  = mRun[i] && (mN[i] != 0) && !rd;
        pop  = eDv && rdy;
        eReq = mRun[i] && !rd && (mN[i] + mPend[i] < DEPTH_C[i] + (pop ? 1 : 0));
        chk("running", i, 32'(run), 32'(mRun[i]));
        chk("imem_req", i, 32'(req), 32'(eReq));
        if (eReq) chk("imem_addr", i, addr, (mHead[i] + (mN[i] + mPend[i]) * STEP_C[i]) & MASK_C[i]);
        chk("dec_valid", i, 32'(dv), 32'(eDv));
        chk("occupancy", i, occ, mN[i]);
        if (eDv) begin
            chk("dec_pc", i, dp, mHead[i]);
            chk("dec_instr", i, di, (mHead[i] >> 2) & MASK_C[i]);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", i, (i == 0) ? pfA : pfB, mFe[i]);
        chk("perf_flushed", i, (i == 0) ? plA : plB, mFl[i]);
`endif
        if (rst) begin
            model_reset(i);
        end else if (!mRun[i]) begin
            if (st) mRun[i] = 1'b1;
        end else if (rd) begin
            sum = longint'(mFl[i]) + longint'(mN[i] + mPend[i]);
            mFl[i]   = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : int'(sum);
            mHead[i] = rdPc & MASK_C[i];
            mN[i]    = 0;
            mPend[i] = 0;
        end else begin
            if (pop) begin
                mHead[i] = (mHead[i] + STEP_C[i]) & MASK_C[i];
                mN[i]    = mN[i] - 1;
                if (mFe[i] != 32'hFFFF_FFFF) mFe[i] = mFe[i] + 1;
            end
            if (mPend[i] != 0) mN[i] = mN[i] + 1;
            mPend[i] = eReq ? 1 : 0;
        end
    endtask

    always @(negedge clk) begin
        if (modelOn) begin
            model_step(0, reset, start, redirA, redirPcA, readyA, reqA, addrA, dvA,
                       instrA, pcA, 32'(occA), runA);
            model_step(1, reset, start, noRedirB, 32'(redirPcB), readyB, reqB, 32'(addrB), dvB,
                       32'(instrB), 32'(pcB), 32'(occB), runB);
        end else if (reset) begin
            model_reset(0);
            model_reset(1);
            modelOn = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values();
        chk("rst_imem_req", 0, 32'(reqA), 32'h0);
        chk("rst_imem_addr", 0, addrA, 32'h0);
        chk("rst_dec_valid", 0, 32'(dvA), 32'h0);
        chk("rst_dec_instr", 0, instrA, 32'h0);
        chk("rst_dec_pc", 0, pcA, 32'h0);
        chk("rst_running", 0, 32'(runA), 32'h0);
        chk("rst_occupancy", 0, 32'(occA), 32'h0);
        chk("rst_running", 1, 32'(runB), 32'h0);
        chk("rst_imem_addr", 1, 32'(addrB), 32'h0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", 0, pfA, 32'h0);
        chk("rst_perf_flushed", 0, plA, 32'h0);
`endif
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; redirA = 1'b0; redirPcA = 32'h0;
        readyA = 1'b1; readyB = 1'b1; noRedirB = 1'b0; redirPcB = 8'h0;
        cyc();
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk_reset_values();
        for (int k = 0; k < 10; k++) begin
            cyc();
            @(negedge clk);
            chk("idle_req", 0, 32'(reqA), 32'h0);
        end

        // Start latency with the decoder always ready.
        start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        chk("c1_running", 0, 32'(runA), 32'h1);
        chk("c1_req", 0, 32'(reqA), 32'h1);
        chk("c1_addr", 0, addrA, 32'h0);
        chk("c1_addr", 1, 32'(addrB), 32'hF8);
        cyc();
        @(negedge clk);
        chk("c2_addr", 0, addrA, 32'h4);
        chk("c2_valid", 0, 32'(dvA), 32'h0);
        cyc();
        @(negedge clk);
        chk("c3_addr", 0, addrA, 32'h8);
        chk("c3_valid", 0, 32'(dvA), 32'h1);
        chk("c3_pc", 0, pcA, 32'h0);
        chk("c3_instr", 0, instrA, 32'h0);
        chk("wrap_pc0", 1, 32'(pcB), 32'hF8);
        cyc();
        @(negedge clk);
        chk("c4_pc", 0, pcA, 32'h4);
        chk("c4_instr", 0, instrA, 32'h1);
        chk("wrap_pc1", 1, 32'(pcB), 32'hFC);
        cyc();
        @(negedge clk);
        chk("wrap_pc2", 1, 32'(pcB), 32'h00);
        cyc();
        @(negedge clk);
        chk("wrap_pc3", 1, 32'(pcB), 32'h04);

        // Two-entry queue with a toggling decoder.
        for (int k = 0; k < 20; k++) begin
            cyc();
            readyB = ~readyB;
        end
        cyc();
        readyB = 1'b1;

        // Fill A to three entries, then reset mid-operation.
        cyc();
        readyA = 1'b0;
        @(negedge clk);
        chk("fill_occ1", 0, 32'(occA), 32'h1);
        cyc();
        @(negedge clk);
        chk("fill_occ2", 0, 32'(occA), 32'h2);
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("fill_occ3", 0, 32'(occA), 32'h3);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk_reset_values();

        // Restart under backpressure.
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 8; k++) cyc();
        @(negedge clk);
        chk("bp_occ", 0, 32'(occA), 32'h4);
        chk("bp_req", 0, 32'(reqA), 32'h0);
        chk("bp_pc", 0, pcA, 32'h0);
        cyc();
        readyA = 1'b1;
        @(negedge clk);
        chk("rel_pc", 0, pcA, 32'h0);
        for (int k = 1; k < 5; k++) begin
            cyc();
            @(negedge clk);
            chk("rel_pc", 0, pcA, 32'(4 * k));
        end

        // Redirect with three queued entries and one response in flight.
        cyc();
        readyA = 1'b0;
        for (int k = 0; k < 6; k++) cyc();
        @(negedge clk);
        chk("full_occ", 0, 32'(occA), 32'h4);
        cyc();
        readyA = 1'b1;
        cyc();
        readyA = 1'b0;
        redirA = 1'b1;
        redirPcA = 32'h100;
        @(negedge clk);
        chk("redir_occ", 0, 32'(occA), 32'h3);
        chk("redir_valid", 0, 32'(dvA), 32'h0);
        chk("redir_req", 0, 32'(reqA), 32'h0);
        cyc();
        redirA = 1'b0;
        readyA = 1'b1;
        @(negedge clk);
        chk("post_occ", 0, 32'(occA), 32'h0);
        chk("post_req", 0, 32'(reqA), 32'h1);
        chk("post_addr", 0, addrA, 32'h100);
`ifdef FETCH_PERF_EN
        chk("post_flushed", 0, plA, 32'h4);
`endif
        cyc();
        @(negedge clk);
        chk("r2_valid", 0, 32'(dvA), 32'h0);
        cyc();
        @(negedge clk);
        chk("r3_pc", 0, pcA, 32'h100);
        chk("r3_instr", 0, instrA, 32'h40);
        cyc();
        @(negedge clk);
        chk("r4_pc", 0, pcA, 32'h104);
        for (int k = 0; k < 5; k++) cyc();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
